// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and frame geometry.
package imem_boot_loader_pkg;

  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_WIDTH     = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Little-endian byte-to-word assembler: shifts bytes into lane cnt and flags the 4th byte.
module word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word_next,
  output logic                  word_full
);

  logic [1:0]            cnt;
  logic [WORD_WIDTH-1:0] word;

  // word_next already carries the incoming byte so the 4th byte can be captured on its own edge
  always_comb begin
    word_next = word;
    word_next[{cnt, 3'b000} +: 8] = byte_in;
  end

  assign word_full = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
    end else if (byte_valid) begin
      word <= word_next;
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte frame and writes the words into instruction memory.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_en,
  output logic [15:0]           words_loaded
);

  localparam logic [LEN_WIDTH-1:0] CAP = LEN_WIDTH'(MEM_CAPACITY);

  state_t                state;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  word_idx;
  logic [LEN_WIDTH-1:0]  len_full;
  logic                  xfer;
  logic                  asm_clear;
  logic                  asm_valid;
  logic                  asm_full;
  logic [WORD_WIDTH-1:0] asm_word;

  assign xfer      = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign asm_valid = xfer && (state == ST_DATA);
  assign asm_clear = (state != ST_DATA) && (state != ST_WRITE);

  word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word_next  (asm_word),
    .word_full  (asm_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      len          <= '0;
      word_idx     <= '0;
      rx_ready     <= 1'b0;
      mem_addr     <= '0;
      mem_wd       <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_en      <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_LEN_LO;
            len          <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            core_en      <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= rx_data;
            if (len_full == '0 || len_full > CAP) begin
              state    <= ST_ERROR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (asm_full) begin
            state    <= ST_WRITE;
            rx_ready <= 1'b0;
            mem_we   <= 1'b1;
            mem_addr <= DATA_WIDTH'({word_idx, 2'b00});
            mem_wd   <= DATA_WIDTH'(asm_word);
          end
        end
        ST_WRITE: begin
          mem_we       <= 1'b0;
          word_idx     <= word_idx + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          if (word_idx + 16'd1 == len) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            core_en <= 1'b1;
          end else begin
            state    <= ST_DATA;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b0;
          mem_we   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued and matched on mem_we.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_en;
  logic [15:0] words_loaded;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tbmem[16];
  logic [31:0] fw[4];
  logic [31:0] keep_w1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.DATA_WIDTH(32), .MEM_CAPACITY(10)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .core_en      (core_en),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model + scoreboard: every write strobe must match the next queued write.
  always @(negedge clk) begin
    if (rstn === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_we observed addr %h wd %h expected no write", mem_addr, mem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("we_addr", mem_addr, e.addr);
        chk("we_wd", mem_wd, e.wd);
      end
      tbmem[mem_addr[5:2]] = mem_wd;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit took;
    int waited;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    took     = 1'b0;
    waited   = 0;
    while (!took && waited < 50) begin
      @(negedge clk);
      took = rx_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (!took) begin
      checks++;
      errors++;
      $error("FAIL rx_timeout observed no rx_ready expected byte %h accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, gapmax));
    chk("write_we", mem_we, 1'b1);
    chk("write_ready", rx_ready, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] n, input int nwords, input int gapmax);
    for (int i = 0; i < nwords; i++) exp_q.push_back('{addr: 32'(i * 4), wd: fw[i]});
    send_byte(n[7:0], $urandom_range(0, gapmax));
    send_byte(n[15:8], $urandom_range(0, gapmax));
    for (int i = 0; i < nwords; i++) send_word(fw[i], gapmax);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, rx_ready, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wd"}, mem_wd, 32'h0);
    chk({tag, "_flags"}, {busy, done, error, core_en}, 4'b0000);
    chk({tag, "_wl"}, words_loaded, 16'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 16; i++) tbmem[i] = '0;

    // Reset, then idle without start
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", rx_ready, 1'b0);

    // N=2 load with exact write latency
    do_start();
    chk("start_ready", rx_ready, 1'b1);
    chk("start_busy", busy, 1'b1);
    fw[0] = 32'h00000013; fw[1] = 32'h00100093;
    send_frame(16'd2, 2, 0);
    chk("lat_done_pre", done, 1'b0);
    @(posedge clk); #1;
    chk("n2_done", done, 1'b1);
    chk("n2_core_en", core_en, 1'b1);
    chk("n2_busy", busy, 1'b0);
    chk("n2_we_off", mem_we, 1'b0);
    chk("n2_wd_hold", mem_wd, 32'h00100093);
    chk("n2_addr_hold", mem_addr, 32'h4);
    chk("n2_wl", words_loaded, 16'd2);
    chk("n2_mem0", tbmem[0], 32'h00000013);
    chk("n2_mem1", tbmem[1], 32'h00100093);

    // Bad lengths: zero and MEM_CAPACITY+1
    do_start();
    chk("restart_done", done, 1'b0);
    chk("restart_core_en", core_en, 1'b0);
    chk("restart_wl", words_loaded, 16'd0);
    send_frame(16'd0, 0, 0);
    chk("n0_error", error, 1'b1);
    chk("n0_ready", rx_ready, 1'b0);
    chk("n0_busy", busy, 1'b0);
    do_start();
    chk("n11_error_clr", error, 1'b0);
    send_frame(16'd11, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("n11_error", error, 1'b1);
    chk("n11_ready", rx_ready, 1'b0);
    chk("n11_core_en", core_en, 1'b0);

    // N=3 with random gaps; bytes offered during WRITE must wait
    do_start();
    fw[0] = 32'hA5A50001; fw[1] = 32'h12345678; fw[2] = 32'hCAFEF00D;
    keep_w1 = fw[1];
    send_frame(16'd3, 3, 3);
    @(posedge clk); #1;
    chk("n3_done", done, 1'b1);
    chk("n3_wl", words_loaded, 16'd3);
    chk("n3_mem2", tbmem[2], 32'hCAFEF00D);

    // Reset mid-load, then a clean frame
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1 rstn = 1'b1;
    do_start();
    fw[0] = 32'h11223344;
    send_frame(16'd1, 1, 0);
    @(posedge clk); #1;
    chk("rst_done", done, 1'b1);
    chk("rst_wl", words_loaded, 16'd1);
    chk("rst_mem0", tbmem[0], 32'h11223344);

    // Reload from DONE
    do_start();
    chk("reload_core_en", core_en, 1'b0);
    fw[0] = 32'hDEADBEEF;
    send_frame(16'd1, 1, 1);
    @(posedge clk); #1;
    chk("reload_done", done, 1'b1);
    chk("reload_core_en2", core_en, 1'b1);
    chk("reload_wl", words_loaded, 16'd1);
    chk("reload_mem0", tbmem[0], 32'hDEADBEEF);
    chk("reload_mem1", tbmem[1], keep_w1);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
